// File: rtl/eval_sram_to_sram_multi_pkg.sv
// Shared definitions for the multi-channel SRAM-to-SRAM copy controller:
// register map, default ID, channel FSM states and the write-strobe expander.
package eval_sram_to_sram_multi_pkg;

  localparam logic [63:0] CORE_ID_DEFAULT = 64'h0000_5352_414d_0002;

  localparam int unsigned REG_ID     = 32'h000;
  localparam int unsigned REG_NUM_CH = 32'h008;
  localparam int unsigned REG_IRQ_EN = 32'h010;
  localparam int unsigned REG_DONE   = 32'h018;

  localparam int unsigned CH_BASE    = 32'h100;
  localparam int unsigned CH_STRIDE  = 32'h020;
  localparam logic [1:0]  CH_CTRL    = 2'd0;
  localparam logic [1:0]  CH_LEN     = 2'd1;
  localparam logic [1:0]  CH_CYCLES  = 2'd2;
  localparam logic [1:0]  CH_CLR     = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Expands an 8-lane byte strobe into a 64-bit bit mask.
  function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/eval_sram_to_sram_ch_ctl.sv
// One copy channel: IDLE/RUN FSM, LEN register and latch, saturating
// CYCLES counter and sticky done flag.
module eval_sram_to_sram_ch_ctl
  import eval_sram_to_sram_multi_pkg::*;
#(
  parameter int unsigned LEN_BITS = 16,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                clr_i,
  input  logic                len_we_i,
  input  logic [LEN_BITS-1:0] len_wdata_i,
  input  logic [LEN_BITS-1:0] len_mask_i,
  input  logic                ch_done_i,
  output logic                ch_start_o,
  output logic                ch_abort_o,
  output logic [LEN_BITS-1:0] ch_len_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LEN_BITS-1:0] len_o,
  output logic [CNT_BITS-1:0] cycles_o
);

  ch_state_t           state_q, state_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic                done_q, done_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] ch_len_q, ch_len_d;
  logic [CNT_BITS-1:0] cycles_q, cycles_d;

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    ch_len_d = ch_len_q;
    len_d    = len_we_i ? ((len_q & ~len_mask_i) | (len_wdata_i & len_mask_i)) : len_q;
    // A completion in the same cycle as CLR wins, so CLR is applied first.
    done_d   = clr_i ? 1'b0 : done_q;
    if (state_q == RUN) begin
      cycles_d = (cycles_q == {CNT_BITS{1'b1}}) ? cycles_q : cycles_q + CNT_BITS'(1);
    end else begin
      cycles_d = cycles_q;
    end
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = RUN;
          start_d  = 1'b1;
          ch_len_d = len_q;
          cycles_d = {CNT_BITS{1'b0}};
          done_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (ch_done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      len_q    <= {LEN_BITS{1'b0}};
      ch_len_q <= {LEN_BITS{1'b0}};
      cycles_q <= {CNT_BITS{1'b0}};
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      len_q    <= len_d;
      ch_len_q <= ch_len_d;
      cycles_q <= cycles_d;
    end
  end

  assign ch_start_o = start_q;
  assign ch_abort_o = abort_q;
  assign ch_len_o   = ch_len_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = done_q;
  assign len_o      = len_q;
  assign cycles_o   = cycles_q;

endmodule

// File: rtl/eval_sram_to_sram_multi_ctl.sv
// AXI4-Lite register slave controlling NUM_CH SRAM-to-SRAM copy channels:
// write/read address decode, AW/W holding, read mux, IRQ_EN and level irq.
module eval_sram_to_sram_multi_ctl
  import eval_sram_to_sram_multi_pkg::*;
#(
  parameter int unsigned AXI4L_ADDR_BITS = 40,
  parameter int unsigned AXI4L_DATA_BITS = 64,
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned LEN_BITS        = 16,
  parameter int unsigned CNT_BITS        = 32,
  parameter logic [63:0] CORE_ID         = CORE_ID_DEFAULT
) (
  input  logic                           s_axi4l_aclk,
  input  logic                           s_axi4l_aresetn,
  input  logic [AXI4L_ADDR_BITS-1:0]     s_axi4l_awaddr,
  input  logic [2:0]                     s_axi4l_awprot,
  input  logic                           s_axi4l_awvalid,
  output logic                           s_axi4l_awready,
  input  logic [AXI4L_DATA_BITS-1:0]     s_axi4l_wdata,
  input  logic [AXI4L_DATA_BITS/8-1:0]   s_axi4l_wstrb,
  input  logic                           s_axi4l_wvalid,
  output logic                           s_axi4l_wready,
  output logic [1:0]                     s_axi4l_bresp,
  output logic                           s_axi4l_bvalid,
  input  logic                           s_axi4l_bready,
  input  logic [AXI4L_ADDR_BITS-1:0]     s_axi4l_araddr,
  input  logic [2:0]                     s_axi4l_arprot,
  input  logic                           s_axi4l_arvalid,
  output logic                           s_axi4l_arready,
  output logic [AXI4L_DATA_BITS-1:0]     s_axi4l_rdata,
  output logic [1:0]                     s_axi4l_rresp,
  output logic                           s_axi4l_rvalid,
  input  logic                           s_axi4l_rready,
  output logic [NUM_CH-1:0]              ch_start,
  output logic [NUM_CH-1:0]              ch_abort,
  output logic [NUM_CH*LEN_BITS-1:0]     ch_len,
  input  logic [NUM_CH-1:0]              ch_done,
  output logic                           irq
);

  localparam int unsigned WA_W = AXI4L_ADDR_BITS - 3;
  localparam logic [WA_W-1:0] WA_ID     = WA_W'(REG_ID >> 3);
  localparam logic [WA_W-1:0] WA_NUM_CH = WA_W'(REG_NUM_CH >> 3);
  localparam logic [WA_W-1:0] WA_IRQ_EN = WA_W'(REG_IRQ_EN >> 3);
  localparam logic [WA_W-1:0] WA_DONE   = WA_W'(REG_DONE >> 3);
  localparam logic [WA_W-1:0] WA_CH_LO  = WA_W'(CH_BASE >> 3);
  localparam logic [WA_W-1:0] WA_CH_HI  = WA_W'((CH_BASE + NUM_CH * CH_STRIDE) >> 3);

  logic                       aw_held_q, aw_held_d;
  logic [AXI4L_ADDR_BITS-1:0] aw_addr_q, aw_addr_d;
  logic                       w_held_q, w_held_d;
  logic [63:0]                w_data_q, w_data_d;
  logic [7:0]                 w_strb_q, w_strb_d;
  logic                       bvalid_q, bvalid_d;
  logic                       rvalid_q, rvalid_d;
  logic [63:0]                rdata_q, rdata_d;
  logic [NUM_CH-1:0]          irq_en_q, irq_en_d;
  logic                       irq_q, irq_d;

  logic                       aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [AXI4L_ADDR_BITS-1:0] wr_addr_s;
  logic [63:0]                w_data_s, mask_s, rd_mux_s;
  logic [7:0]                 w_strb_s;
  logic [WA_W-1:0]            wr_wa_s, wr_ofs_s, rd_wa_s, rd_ofs_s;
  logic                       wr_ch_hit_s, rd_ch_hit_s, irq_en_we_s;
  logic [NUM_CH-1:0]          ch_sel_s, start_s, abort_s, clr_s, len_we_s;
  logic [NUM_CH-1:0]          busy_s, done_s;
  logic [LEN_BITS-1:0]        len_s [NUM_CH];
  logic [LEN_BITS-1:0]        ch_len_s [NUM_CH];
  logic [CNT_BITS-1:0]        cycles_s [NUM_CH];
  logic                       unused_s;

  assign s_axi4l_awready = !aw_held_q && !bvalid_q;
  assign s_axi4l_wready  = !w_held_q && !bvalid_q;
  assign s_axi4l_arready = !rvalid_q;
  assign s_axi4l_bvalid  = bvalid_q;
  assign s_axi4l_bresp   = 2'b00;
  assign s_axi4l_rvalid  = rvalid_q;
  assign s_axi4l_rdata   = rdata_q;
  assign s_axi4l_rresp   = 2'b00;
  assign irq             = irq_q;

  assign aw_hs_s   = s_axi4l_awvalid && s_axi4l_awready;
  assign w_hs_s    = s_axi4l_wvalid && s_axi4l_wready;
  assign ar_hs_s   = s_axi4l_arvalid && s_axi4l_arready;
  assign commit_s  = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
  assign wr_addr_s = aw_held_q ? aw_addr_q : s_axi4l_awaddr;
  assign w_data_s  = w_held_q ? w_data_q : s_axi4l_wdata;
  assign w_strb_s  = w_held_q ? w_strb_q : s_axi4l_wstrb;
  assign mask_s    = strb_to_mask(w_strb_s);

  // Write decode: the channel region is 4 words per channel above WA_CH_LO.
  always_comb begin
    wr_wa_s     = wr_addr_s[AXI4L_ADDR_BITS-1:3];
    wr_ofs_s    = wr_wa_s - WA_CH_LO;
    wr_ch_hit_s = commit_s && (wr_wa_s >= WA_CH_LO) && (wr_wa_s < WA_CH_HI);
    irq_en_we_s = commit_s && (wr_wa_s == WA_IRQ_EN);
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel_s[c] = wr_ch_hit_s && (wr_ofs_s[5:2] == 4'(c));
      start_s[c]  = ch_sel_s[c] && (wr_ofs_s[1:0] == CH_CTRL) && w_strb_s[0] && w_data_s[0];
      abort_s[c]  = ch_sel_s[c] && (wr_ofs_s[1:0] == CH_CTRL) && w_strb_s[0] && w_data_s[1];
      len_we_s[c] = ch_sel_s[c] && (wr_ofs_s[1:0] == CH_LEN);
      clr_s[c]    = ch_sel_s[c] && (wr_ofs_s[1:0] == CH_CLR) && w_strb_s[0] && w_data_s[0];
    end
  end

  // Read mux over current register state.
  always_comb begin
    rd_wa_s     = s_axi4l_araddr[AXI4L_ADDR_BITS-1:3];
    rd_ofs_s    = rd_wa_s - WA_CH_LO;
    rd_ch_hit_s = (rd_wa_s >= WA_CH_LO) && (rd_wa_s < WA_CH_HI);
    rd_mux_s    = 64'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (rd_ofs_s[1:0])
        CH_CTRL:   rd_mux_s = (rd_ch_hit_s && rd_ofs_s[5:2] == 4'(c)) ? {62'd0, done_s[c], busy_s[c]} : rd_mux_s;
        CH_LEN:    rd_mux_s = (rd_ch_hit_s && rd_ofs_s[5:2] == 4'(c)) ? 64'(len_s[c]) : rd_mux_s;
        CH_CYCLES: rd_mux_s = (rd_ch_hit_s && rd_ofs_s[5:2] == 4'(c)) ? 64'(cycles_s[c]) : rd_mux_s;
        default:   rd_mux_s = rd_mux_s;
      endcase
    end
    case (rd_wa_s)
      WA_ID:     rd_mux_s = CORE_ID;
      WA_NUM_CH: rd_mux_s = 64'(NUM_CH);
      WA_IRQ_EN: rd_mux_s = 64'(irq_en_q);
      WA_DONE:   rd_mux_s = 64'(done_s);
      default:   rd_mux_s = rd_mux_s;
    endcase
  end

  // Handshake, holding-register and IRQ next-state.
  always_comb begin
    aw_held_d = commit_s ? 1'b0 : (aw_hs_s ? 1'b1 : aw_held_q);
    aw_addr_d = aw_hs_s ? s_axi4l_awaddr : aw_addr_q;
    w_held_d  = commit_s ? 1'b0 : (w_hs_s ? 1'b1 : w_held_q);
    w_data_d  = w_hs_s ? s_axi4l_wdata : w_data_q;
    w_strb_d  = w_hs_s ? s_axi4l_wstrb : w_strb_q;
    bvalid_d  = commit_s ? 1'b1 : ((bvalid_q && s_axi4l_bready) ? 1'b0 : bvalid_q);
    rvalid_d  = ar_hs_s ? 1'b1 : ((rvalid_q && s_axi4l_rready) ? 1'b0 : rvalid_q);
    rdata_d   = ar_hs_s ? rd_mux_s : rdata_q;
    irq_en_d  = irq_en_we_s ? ((irq_en_q & ~mask_s[NUM_CH-1:0]) | (w_data_s[NUM_CH-1:0] & mask_s[NUM_CH-1:0]))
                            : irq_en_q;
    irq_d     = |(done_s & irq_en_q);
  end

  always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
    if (!s_axi4l_aresetn) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= {AXI4L_ADDR_BITS{1'b0}};
      w_held_q  <= 1'b0;
      w_data_q  <= 64'd0;
      w_strb_q  <= 8'd0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'd0;
      irq_en_q  <= {NUM_CH{1'b0}};
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    eval_sram_to_sram_ch_ctl #(
      .LEN_BITS (LEN_BITS),
      .CNT_BITS (CNT_BITS)
    ) u_ch (
      .clk_i       (s_axi4l_aclk),
      .rst_ni      (s_axi4l_aresetn),
      .start_i     (start_s[c]),
      .abort_i     (abort_s[c]),
      .clr_i       (clr_s[c]),
      .len_we_i    (len_we_s[c]),
      .len_wdata_i (w_data_s[LEN_BITS-1:0]),
      .len_mask_i  (mask_s[LEN_BITS-1:0]),
      .ch_done_i   (ch_done[c]),
      .ch_start_o  (ch_start[c]),
      .ch_abort_o  (ch_abort[c]),
      .ch_len_o    (ch_len_s[c]),
      .busy_o      (busy_s[c]),
      .done_o      (done_s[c]),
      .len_o       (len_s[c]),
      .cycles_o    (cycles_s[c])
    );
    assign ch_len[c*LEN_BITS +: LEN_BITS] = ch_len_s[c];
  end

  assign unused_s = ^{s_axi4l_awprot, s_axi4l_arprot, wr_addr_s[2:0], s_axi4l_araddr[2:0],
                      wr_ofs_s, rd_ofs_s, mask_s, w_data_s, w_strb_s};

endmodule

// File: tb/tb_eval_sram_to_sram_multi_ctl.sv
// Directed bench for eval_sram_to_sram_multi_ctl; read results are checked
// against a queue of expected values pushed when each read is issued.
module tb_eval_sram_to_sram_multi_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [63:0] wdata = '0, rdata;
  logic [7:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic [3:0]  ch_start, ch_abort, ch_done = '0;
  logic [63:0] ch_len;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  eval_sram_to_sram_multi_ctl dut (
    .s_axi4l_aclk    (clk),
    .s_axi4l_aresetn (rst_n),
    .s_axi4l_awaddr  (awaddr),
    .s_axi4l_awprot  (awprot),
    .s_axi4l_awvalid (awvalid),
    .s_axi4l_awready (awready),
    .s_axi4l_wdata   (wdata),
    .s_axi4l_wstrb   (wstrb),
    .s_axi4l_wvalid  (wvalid),
    .s_axi4l_wready  (wready),
    .s_axi4l_bresp   (bresp),
    .s_axi4l_bvalid  (bvalid),
    .s_axi4l_bready  (bready),
    .s_axi4l_araddr  (araddr),
    .s_axi4l_arprot  (arprot),
    .s_axi4l_arvalid (arvalid),
    .s_axi4l_arready (arready),
    .s_axi4l_rdata   (rdata),
    .s_axi4l_rresp   (rresp),
    .s_axi4l_rvalid  (rvalid),
    .s_axi4l_rready  (rready),
    .ch_start        (ch_start),
    .ch_abort        (ch_abort),
    .ch_len          (ch_len),
    .ch_done         (ch_done),
    .irq             (irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write transaction; dn is driven on ch_done during the commit cycle.
  // Returns at the falling edge just after the commit edge.
  task automatic axi_write(input string tag, input logic [39:0] a, input logic [63:0] d,
                           input logic [7:0] s, input logic [3:0] dn);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; ch_done = dn;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_awwready"}, 64'(awready && wready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; ch_done = 4'd0;
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(bresp), 64'd0);
  endtask

  task automatic axi_read(input string tag, input logic [39:0] a, input logic [63:0] e);
    int n;
    exp_q.push_back(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arready"}, 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    chk(tag, rdata, exp_q.pop_front());
    chk({tag, "_rresp"}, 64'(rresp), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ch_start", 64'(ch_start), 64'd0);
    chk("rst_ch_abort", 64'(ch_abort), 64'd0);
    chk("rst_ch_len", ch_len, 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'({awready, wready, arready}), 64'd7);

    axi_read("id", 40'h000, 64'h0000_5352_414d_0002);
    axi_read("num_ch", 40'h008, 64'd4);
    axi_read("cyc0_rst", 40'h110, 64'd0);
    axi_read("unmapped_hi", 40'h180, 64'd0);
    axi_read("unmapped_lo", 40'h020, 64'd0);

    // Channel 1 transfer, ch_done sampled 10 edges after the start edge
    axi_write("len1", 40'h128, 64'h0123, 8'hFF, 4'd0);
    axi_write("start1", 40'h120, 64'd1, 8'hFF, 4'd0);
    chk("ch1_start", 64'(ch_start), 64'h2);
    chk("ch1_len", 64'(ch_len[31:16]), 64'h0123);
    @(negedge clk);
    chk("ch1_start_pulse", 64'(ch_start), 64'h0);
    repeat (8) @(negedge clk);
    ch_done = 4'b0010;
    @(negedge clk);
    ch_done = 4'b0000;
    axi_read("ctrl1", 40'h120, 64'd2);
    axi_read("cyc1", 40'h130, 64'd10);
    axi_read("done_vec", 40'h018, 64'h2);

    // IRQ: enable ch1, complete again, then clear
    axi_write("clr1", 40'h138, 64'd1, 8'hFF, 4'd0);
    axi_write("irq_en", 40'h010, 64'h2, 8'hFF, 4'd0);
    axi_read("irq_en_rd", 40'h010, 64'h2);
    chk("irq_before", 64'(irq), 64'd0);
    axi_write("start1b", 40'h120, 64'd1, 8'hFF, 4'd0);
    @(negedge clk);
    ch_done = 4'b0010;
    @(negedge clk);
    ch_done = 4'b0000;
    chk("irq_latency", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_set", 64'(irq), 64'd1);
    axi_write("clr1b", 40'h138, 64'd1, 8'hFF, 4'd0);
    chk("irq_clr_lat", 64'(irq), 64'd1);
    @(negedge clk);
    chk("irq_clr", 64'(irq), 64'd0);

    // Channel 2: ch_done beats a simultaneous abort, then a real abort
    axi_write("start2", 40'h140, 64'd1, 8'hFF, 4'd0);
    repeat (3) @(negedge clk);
    axi_write("abort2_race", 40'h140, 64'd2, 8'hFF, 4'b0100);
    chk("ch2_no_abort", 64'(ch_abort), 64'd0);
    axi_read("ctrl2_done", 40'h140, 64'd2);
    axi_write("start2b", 40'h140, 64'd1, 8'hFF, 4'd0);
    axi_write("abort2", 40'h140, 64'd2, 8'hFF, 4'd0);
    chk("ch2_abort", 64'(ch_abort), 64'h4);
    axi_read("ctrl2_idle", 40'h140, 64'd0);
    axi_write("abort2_idle", 40'h140, 64'd2, 8'hFF, 4'd0);
    chk("ch2_idle_abort", 64'(ch_abort), 64'd0);
    axi_write("both2", 40'h140, 64'd3, 8'hFF, 4'd0);
    chk("ch2_both_start", 64'(ch_start), 64'd0);
    axi_read("ctrl2_both", 40'h140, 64'd0);

    // Channel 3: start while running ignored; CLR with ch_done leaves done set
    axi_write("start3", 40'h160, 64'd1, 8'hFF, 4'd0);
    chk("ch3_start", 64'(ch_start), 64'h8);
    axi_write("start3_again", 40'h160, 64'd1, 8'hFF, 4'd0);
    chk("ch3_restart", 64'(ch_start), 64'd0);
    axi_read("ctrl3_busy", 40'h160, 64'd1);
    axi_write("clr3_done", 40'h178, 64'd1, 8'hFF, 4'b1000);
    axi_read("ctrl3_done", 40'h160, 64'd2);

    // wstrb[0] gates CTRL; ch_done while idle is ignored; LEN byte lanes
    axi_write("ctrl0_nostrb", 40'h100, 64'd1, 8'hFE, 4'd0);
    chk("ch0_nostrb", 64'(ch_start), 64'd0);
    axi_read("ctrl0_idle", 40'h100, 64'd0);
    @(negedge clk);
    ch_done = 4'b0001;
    @(negedge clk);
    ch_done = 4'b0000;
    axi_read("done_vec2", 40'h018, 64'h8);
    axi_write("len0_lane", 40'h108, 64'hBBCC, 8'h01, 4'd0);
    axi_read("len0_lane_rd", 40'h108, 64'h00CC);
    axi_write("unmapped_wr", 40'h188, 64'hFFFF, 8'hFF, 4'd0);

    // W three cycles ahead of AW, bready held low for five cycles
    @(negedge clk);
    wdata = 64'h0055; wstrb = 8'h01; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    chk("w_held_wready", 64'({awready, wready}), 64'b10);
    @(negedge clk);
    @(negedge clk);
    awaddr = 40'h108; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("b_hold_bvalid", 64'(bvalid), 64'd1);
      chk("b_hold_ready", 64'({awready, wready}), 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("b_done_bvalid", 64'(bvalid), 64'd0);
    chk("b_done_ready", 64'({awready, wready}), 64'b11);
    axi_read("len0_split", 40'h108, 64'h0055);

    // Reset while channel 0 is running
    axi_write("irq_en3", 40'h010, 64'h8, 8'hFF, 4'd0);
    axi_write("start0", 40'h100, 64'd1, 8'hFF, 4'd0);
    chk("ch0_len", 64'(ch_len[15:0]), 64'h0055);
    repeat (50) @(negedge clk);
    chk("irq_pre_rst", 64'(irq), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_len", ch_len, 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_pulses", 64'({ch_start, ch_abort}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read("cyc0_after", 40'h110, 64'd0);
    axi_read("ctrl0_after", 40'h100, 64'd0);
    axi_read("len0_after", 40'h108, 64'd0);
    axi_read("irq_en_after", 40'h010, 64'd0);
    axi_read("done_after", 40'h018, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
